// File: rtl/fifo_ctrl_param.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_param
// Parametrised synchronous FIFO with first-word-fall-through read side.
// It sits between a producer stage and the consuming pipeline stage. It holds
// a storage array, head/tail pointers, an occupancy count, full/empty/almost
// flags and sticky overflow/underflow error flags.
//
// Parameters
//   DATA_W    width of each stored word
//   DEPTH     number of entries (>= 2, any value, not only powers of two)
//   AF_LEVEL  almost_full  when count >= AF_LEVEL
//   AE_LEVEL  almost_empty when count <= AE_LEVEL
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-low reset (0 = reset)
//   data_in_valid   push request
//   data_in         push data
//   data_out_ready  pop request
//   data_out        word at head (valid while data_out_valid)
//   data_out_valid  FIFO not empty
//   fifo_full       count == DEPTH
//   fifo_empty      count == 0
//   almost_full     count >= AF_LEVEL
//   almost_empty    count <= AE_LEVEL
//   count           current occupancy
//   curr_head       read pointer
//   curr_tail       write pointer
//   overflow        sticky: a push was rejected
//   underflow       sticky: a pop was rejected
//   err_clr         synchronous clear of overflow/underflow
// ---------------------------------------------------------------------------
module fifo_ctrl_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3,
    parameter int AE_LEVEL = 1,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_in_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic [PTR_W-1:0]  curr_head,
    output logic [PTR_W-1:0]  curr_tail,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    // Storage is deliberately left unreset; only the control state is cleared.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;

    logic pop_ok;
    logic push_ok;

    // Explicit wrap at DEPTH-1 so non-power-of-two depths never visit
    // indices beyond the array.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Flags are decoded straight from the registered count.
    assign fifo_empty     = (count_reg == '0);
    assign fifo_full      = (count_reg == CNT_W'(DEPTH));
    assign almost_full    = (count_reg >= CNT_W'(AF_LEVEL));
    assign almost_empty   = (count_reg <= CNT_W'(AE_LEVEL));
    assign data_out_valid = ~fifo_empty;
    assign count          = count_reg;
    assign curr_head      = head_reg;
    assign curr_tail      = tail_reg;
    assign overflow       = overflow_reg;
    assign underflow      = underflow_reg;

    // Fall-through read: the head word is presented without a read cycle.
    assign data_out = mem[head_reg];

    // A pop on a full FIFO frees the slot the simultaneous push writes into,
    // so a full FIFO still accepts a push when it is also popped.
    assign pop_ok  = data_out_ready & ~fifo_empty;
    assign push_ok = data_in_valid & (~fifo_full | pop_ok);

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;

        if (pop_ok) begin
            head_next = ptr_inc(head_reg);
        end
        if (push_ok) begin
            tail_next = ptr_inc(tail_reg);
        end

        if (push_ok && !pop_ok) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - CNT_W'(1);
        end

        // A fresh error in the clearing cycle keeps the flag set.
        overflow_next  = (overflow_reg  & ~err_clr) | (data_in_valid  & ~push_ok);
        underflow_next = (underflow_reg & ~err_clr) | (data_out_ready & fifo_empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail_reg] <= data_in;
        end
    end

endmodule
